nn_scaler_engine: RTL and testbench

- Streaming nearest-neighbour scaler: walks the whole destination frame, fetches source pixels from an external synchronous ROM/RAM, and emits destination pixels on a valid/ready stream.
- Supports integer zoom-in (pixel/row replication) and zoom-out (decimation) by a runtime factor.
- Replaces per-pixel division with incremental counters and row-base accumulation.
- Sits between the image ROM and the VGA/frame-buffer writer.

---
 rtl/nn_scaler_engine.sv | 211 +++++++++++++++++++++
 tb/tb_nn_scaler_engine.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_scaler_engine.sv
// Streaming nearest-neighbour scaler: ROM fetch to valid/ready pixel stream.
// Optional horizontal flip is enabled by defining NN_SCALER_MIRROR_EN.
module nn_scaler_engine #(
  parameter int SRC_W      = 320,
  parameter int SRC_H      = 240,
  parameter int PIX_W      = 8,
  parameter int MEM_LAT    = 1,
  parameter int MAX_FACTOR = 4,
  parameter int ADDR_W     = $clog2(SRC_W*SRC_H)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef NN_SCALER_MIRROR_EN
  input  logic              mirror,
`endif
  input  logic              start,
  input  logic              mode,
  input  logic [2:0]        factor,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam int RW = (MAX_FACTOR > 1) ? $clog2(MAX_FACTOR) : 1;
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [XW-1:0] X_MAX = XW'(SRC_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(SRC_H - 1);
  localparam logic [2:0]    F_MAX = 3'(MAX_FACTOR);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT,
    FIN
  } state_t;

  state_t state, state_n;

  logic              mode_q;
  logic [2:0]        fac_q;
  logic              mir_q;
  logic [XW-1:0]     src_x, n_x;
  logic [YW-1:0]     src_y, n_y;
  logic [RW-1:0]     rep_x, n_rx;
  logic [RW-1:0]     rep_y, n_ry;
  logic [ADDR_W-1:0] row_base, n_base;
  logic [ADDR_W-1:0] row_step;
  logic [LW-1:0]     wcnt;

  logic              fac_ok;
  logic              go;
  logic              lat_hit;
  logic              hs;
  logic              last_x, last_y;
  logic              last_rx, last_ry;
  logic [XW+3:0]     nx;
  logic [YW+3:0]     ny;
  logic              col_end;
  logic              frame_last;
  logic              reuse;
  logic [XW-1:0]     addr_x;

  assign fac_ok  = (factor != 3'd0) && (factor <= F_MAX);
  assign go      = (state == IDLE) && start && fac_ok;
  assign lat_hit = (wcnt == LW'(MEM_LAT - 1));
  assign hs      = (state == OUT) && pix_ready;

  assign last_x  = (src_x == X_MAX);
  assign last_y  = (src_y == Y_MAX);
  assign last_rx = (rep_x == RW'(fac_q - 3'd1));
  assign last_ry = (rep_y == RW'(fac_q - 3'd1));

  // Zoom-out steps compared in a wider width so the overrun is visible.
  assign nx      = (XW+4)'(src_x) + (XW+4)'(fac_q);
  assign ny      = (YW+4)'(src_y) + (YW+4)'(fac_q);
  assign col_end = nx > (XW+4)'(SRC_W - 1);

  always_comb begin
    frame_last = 1'b0;
    if (mode_q)
      frame_last = col_end && (ny > (YW+4)'(SRC_H - 1));
    else
      frame_last = last_x && last_rx && last_ry && last_y;
  end

  always_comb begin
    n_x    = src_x;
    n_y    = src_y;
    n_rx   = rep_x;
    n_ry   = rep_y;
    n_base = row_base;
    reuse  = 1'b0;
    if (mode_q) begin
      if (col_end) begin
        n_x    = '0;
        n_y    = ny[YW-1:0];
        n_base = row_base + row_step;
      end else begin
        n_x    = nx[XW-1:0];
      end
    end else if (!last_rx) begin
      n_rx  = rep_x + 1'b1;
      reuse = 1'b1;
    end else begin
      n_rx = '0;
      if (!last_x) begin
        n_x = src_x + 1'b1;
      end else begin
        n_x = '0;
        if (!last_ry) begin
          n_ry = rep_y + 1'b1;
        end else begin
          n_ry   = '0;
          n_y    = src_y + 1'b1;
          n_base = row_base + row_step;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (go) state_n = ISSUE;
      ISSUE: state_n = WAIT;
      WAIT:  if (lat_hit) state_n = OUT;
      OUT: begin
        if (pix_ready) begin
          if (frame_last)  state_n = FIN;
          else if (reuse)  state_n = OUT;
          else             state_n = ISSUE;
        end
      end
      FIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= 1'b0;
      fac_q    <= 3'd0;
      src_x    <= '0;
      src_y    <= '0;
      rep_x    <= '0;
      rep_y    <= '0;
      row_base <= '0;
      row_step <= '0;
      wcnt     <= '0;
      pix_out  <= '0;
      err      <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && !fac_ok;
      if (go) begin
        mode_q   <= mode;
        fac_q    <= factor;
        src_x    <= '0;
        src_y    <= '0;
        rep_x    <= '0;
        rep_y    <= '0;
        row_base <= '0;
        row_step <= mode ? ADDR_W'(SRC_W) * ADDR_W'(factor)
                         : ADDR_W'(SRC_W);
      end
      if (hs && !frame_last) begin
        src_x    <= n_x;
        src_y    <= n_y;
        rep_x    <= n_rx;
        rep_y    <= n_ry;
        row_base <= n_base;
      end
      if (state == WAIT) wcnt <= wcnt + 1'b1;
      else               wcnt <= '0;
      if (state == WAIT && lat_hit) pix_out <= rd_data;
    end
  end

`ifdef NN_SCALER_MIRROR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     mir_q <= 1'b0;
    else if (go) mir_q <= mirror;
  end
`else
  assign mir_q = 1'b0;
`endif

  assign addr_x    = mir_q ? (X_MAX - src_x) : src_x;
  assign rd_en     = (state == ISSUE);
  assign rd_addr   = rd_en ? (row_base + ADDR_W'(addr_x)) : '0;
  assign pix_valid = (state == OUT);
  assign pix_last  = (state == OUT) && frame_last;
  assign busy      = (state == ISSUE) || (state == WAIT) || (state == OUT);
  assign done      = (state == FIN);

endmodule

// File: tb/tb_nn_scaler_engine.sv
// Scoreboard bench for nn_scaler_engine on a 4x2 source, ROM[i]=i.
module tb_nn_scaler_engine;

  localparam int SRC_W   = 4;
  localparam int SRC_H   = 2;
  localparam int PIX_W   = 8;
  localparam int MEM_LAT = 3;
  localparam int MAXF    = 4;
  localparam int ADDR_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mode;
  logic [2:0]        factor;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [PIX_W-1:0]  pix_out;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;
  logic              busy;
  logic              done;
  logic              err;

  typedef struct packed {
    logic [PIX_W-1:0] v;
    logic             last;
  } exp_t;

  exp_t              sb[$];
  exp_t              e;
  logic [ADDR_W-1:0] rd_log[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int last_cyc = -10;

  nn_scaler_engine #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .PIX_W(PIX_W),
    .MEM_LAT(MEM_LAT), .MAX_FACTOR(MAXF), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef NN_SCALER_MIRROR_EN
    .mirror(1'b0),
`endif
    .start(start), .mode(mode), .factor(factor),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_out(pix_out), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [PIX_W-1:0] pipe [MEM_LAT];
  always @(posedge clk) begin
    pipe[0] <= PIX_W'(rd_addr);
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rd_data = pipe[MEM_LAT-1];

  always @(negedge clk) begin
    cyc++;
    if (rd_en) begin
      rd_cnt++;
      rd_log.push_back(rd_addr);
    end
    if (pix_valid && pix_ready) begin
      hs_cnt++;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL extra_pixel got %0d last=%0b, none expected",
                 pix_out, pix_last);
      end else begin
        e = sb.pop_front();
        if ({pix_out, pix_last} !== e) begin
          n_fail++;
          $display("FAIL pixel got %0d/%0b want %0d/%0b",
                   pix_out, pix_last, e.v, e.last);
        end
      end
      if (pix_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      n_tests++;
      if (cyc !== last_cyc + 1) begin
        n_fail++;
        $display("FAIL done_timing got cycle %0d want %0d",
                 cyc, last_cyc + 1);
      end
    end
  end

  task automatic push_frame(input logic m, input int f);
    exp_t x;
    int w, h;
    if (!m) begin
      w = SRC_W * f;
      h = SRC_H * f;
    end else begin
      w = (SRC_W + f - 1) / f;
      h = (SRC_H + f - 1) / f;
    end
    for (int y = 0; y < h; y++)
      for (int xi = 0; xi < w; xi++) begin
        if (!m) x.v = PIX_W'((y / f) * SRC_W + xi / f);
        else    x.v = PIX_W'(y * f * SRC_W + xi * f);
        x.last = (y == h - 1) && (xi == w - 1);
        sb.push_back(x);
      end
  endtask

  task automatic pulse_start(input logic m, input logic [2:0] f);
    @(posedge clk); #1;
    mode = m;
    factor = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout got none within %0d cycles", budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input int h0, input int k);
    int n = 0;
    while (hs_cnt - h0 < k && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    factor = 3'd1;
    pix_ready = 1'b1;
    #12;
    n_tests++;
    if ({rd_en, rd_addr, pix_out, pix_valid, pix_last, busy, done, err}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 0",
               {rd_en, rd_addr, pix_out, pix_valid, pix_last, busy, done, err});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_frame(input string nm, input int r0, input int h0,
                             input int d0, input int rd_exp, input int px);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing got %0d left want 0", nm, sb.size());
    end
    n_tests++;
    if (rd_cnt - r0 != rd_exp) begin
      n_fail++;
      $display("FAIL %s_reads got %0d want %0d", nm, rd_cnt - r0, rd_exp);
    end
    n_tests++;
    if (hs_cnt - h0 != px) begin
      n_fail++;
      $display("FAIL %s_pixels got %0d want %0d", nm, hs_cnt - h0, px);
    end
    n_tests++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL %s_done got %0d want 1", nm, done_cnt - d0);
    end
  endtask

  task automatic test_zoom_in();
    int r0 = rd_cnt, h0 = hs_cnt, d0 = done_cnt;
    push_frame(1'b0, 2);
    pulse_start(1'b0, 3'd2);
    wait_done(2000);
    check_frame("zoom_in", r0, h0, d0, 16, 32);
  endtask

  task automatic test_zoom_out();
    int r0 = rd_cnt, h0 = hs_cnt, d0 = done_cnt;
    rd_log.delete();
    push_frame(1'b1, 2);
    pulse_start(1'b1, 3'd2);
    wait_done(500);
    check_frame("zoom_out", r0, h0, d0, 2, 2);
    n_tests++;
    if (rd_log.size() != 2 || rd_log[0] !== 3'd0 || rd_log[1] !== 3'd2) begin
      n_fail++;
      $display("FAIL zoom_out_addr got %0d entries want 0 then 2",
               rd_log.size());
    end
  endtask

  task automatic test_latency();
    int n = 0;
    int r0 = rd_cnt, h0 = hs_cnt, d0 = done_cnt;
    push_frame(1'b0, 1);
    @(posedge clk); #1;
    mode = 1'b0;
    factor = 3'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!pix_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (n != MEM_LAT + 1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_valid got %0d cycles busy=%0b want %0d busy=1",
               n, busy, MEM_LAT + 1);
    end
    wait_done(1000);
    check_frame("copy", r0, h0, d0, 8, 8);
  endtask

  task automatic test_backpressure();
    int n = 0;
    int r0 = rd_cnt, h0 = hs_cnt, d0 = done_cnt;
    int rs;
    logic [PIX_W-1:0] po;
    push_frame(1'b0, 2);
    pulse_start(1'b0, 3'd2);
    wait_hs(h0, 5);
    @(posedge clk); #1;
    pix_ready = 1'b0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!pix_valid && n < 20);
    po = pix_out;
    rs = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (pix_valid !== 1'b1 || pix_out !== po) begin
        n_fail++;
        $display("FAIL stall_hold got %0b/%0d want 1/%0d",
                 pix_valid, pix_out, po);
      end
    end
    n_tests++;
    if (rd_cnt != rs) begin
      n_fail++;
      $display("FAIL stall_reads got %0d want %0d", rd_cnt, rs);
    end
    @(posedge clk); #1;
    pix_ready = 1'b1;
    wait_done(2000);
    check_frame("stall", r0, h0, d0, 16, 32);
  endtask

  task automatic test_err();
    logic [2:0] bad [2];
    int r0 = rd_cnt;
    bad[0] = 3'd0;
    bad[1] = 3'd5;
    for (int i = 0; i < 2; i++) begin
      pulse_start(1'b0, bad[i]);
      n_tests++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL err_pulse f=%0d got err=%0b busy=%0b want 1/0",
                 bad[i], err, busy);
      end
      @(posedge clk); #1;
      n_tests++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL err_width f=%0d got err=%0b busy=%0b want 0/0",
                 bad[i], err, busy);
      end
      repeat (3) @(posedge clk);
    end
    n_tests++;
    if (rd_cnt != r0) begin
      n_fail++;
      $display("FAIL err_reads got %0d want %0d", rd_cnt - r0, 0);
    end
  endtask

  task automatic test_reset_midframe();
    int h0 = hs_cnt, d0 = done_cnt, r0;
    push_frame(1'b0, 2);
    pulse_start(1'b0, 3'd2);
    wait_hs(h0, 10);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({rd_en, rd_addr, pix_out, pix_valid, pix_last, busy, done, err}
        !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs got %b want 0",
               {rd_en, rd_addr, pix_out, pix_valid, pix_last, busy, done, err});
    end
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (done_cnt != d0) begin
      n_fail++;
      $display("FAIL midreset_done got %0d want %0d", done_cnt, d0);
    end
    r0 = rd_cnt;
    h0 = hs_cnt;
    d0 = done_cnt;
    push_frame(1'b0, 2);
    pulse_start(1'b0, 3'd2);
    wait_done(2000);
    check_frame("restart", r0, h0, d0, 16, 32);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zoom_in();
    test_zoom_out();
    test_latency();
    test_backpressure();
    test_err();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
